// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one 8-bit holding register among four requesters.
// Define REG_ARB_PARITY_EN to add the registered even-parity output reg_par.
module reg_write_arbiter #(
   parameter int HOLD_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  req,
   input  logic [31:0] req_data,
   input  logic        clear,
   output logic [3:0]  ack,
   output logic [7:0]  reg_q,
   output logic [1:0]  reg_owner,
   output logic        reg_valid,
   output logic        busy
`ifdef REG_ARB_PARITY_EN
   ,
   output logic        reg_par
`endif
);

   localparam logic [0:0] IDLE      = 1'b0;
   localparam logic [0:0] HOLD      = 1'b1;
   localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

   logic [0:0] state_q, state_d;
   logic [1:0] ptr_q, ptr_d;
   logic [3:0] hcnt_q, hcnt_d;
   logic [3:0] ack_q, ack_d;
   logic [7:0] data_q, data_d;
   logic [1:0] owner_q, owner_d;
   logic       valid_q, valid_d;

   logic       win_found;
   logic [1:0] win_idx;
   logic [1:0] cand;
   logic       load;

   // Rotating priority search starting at ptr; first requester found wins.
   always_comb begin
      win_found = 1'b0;
      win_idx   = ptr_q;
      cand      = ptr_q;
      for (int k = 0; k < 4; k++) begin
         cand = ptr_q + 2'(k);
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   assign load = (state_q == IDLE) && win_found;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      hcnt_d  = hcnt_q;
      ack_d   = 4'b0000;
      data_d  = data_q;
      owner_d = owner_q;
      valid_d = valid_q;
      if (load) begin
         state_d = HOLD;
         ptr_d   = win_idx + 2'd1;
         hcnt_d  = HOLD_LOAD;
         ack_d   = 4'b0001 << win_idx;
         data_d  = req_data[{win_idx, 3'b000} +: 8];
         owner_d = win_idx;
         valid_d = 1'b1;
      end else begin
         if (state_q == HOLD) begin
            if (hcnt_q == 4'd0) begin
               state_d = IDLE;
            end else begin
               hcnt_d = hcnt_q - 4'd1;
            end
         end
         // A same-edge load takes precedence, so clear only acts here.
         if (clear) begin
            data_d  = 8'h00;
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= 2'd0;
         hcnt_q  <= 4'd0;
         ack_q   <= 4'b0000;
         data_q  <= 8'h00;
         owner_q <= 2'd0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         hcnt_q  <= hcnt_d;
         ack_q   <= ack_d;
         data_q  <= data_d;
         owner_q <= owner_d;
         valid_q <= valid_d;
      end
   end

`ifdef REG_ARB_PARITY_EN
   logic par_q, par_d;

   assign par_d = ^data_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         par_q <= 1'b0;
      end else begin
         par_q <= par_d;
      end
   end

   assign reg_par = par_q;
`endif

   assign ack       = ack_q;
   assign reg_q     = data_q;
   assign reg_owner = owner_q;
   assign reg_valid = valid_q;
   assign busy      = (state_q == HOLD);

endmodule
